ni_packetizer: RTL and testbench

- Network-interface transmit side for the 2x4 mesh NoC.
- Accepts a packet request (destination node, payload length) and a payload word stream from the local core. Serialises them into head/body/tail flits on the router's local input port.
- The head flit carries the destination address that the router's route-compute stage decodes. Flow control toward the router is credit-based.

---
 rtl/ni_packetizer_pkg.sv | 27 ++
 rtl/ni_credit_counter.sv | 52 +++++
 rtl/ni_packetizer.sv | 136 +++++++++++++
 tb/tb_ni_packetizer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ni_packetizer_pkg.sv
// Shared definitions for the network-interface transmit path: flit type codes,
// head-flit field offsets and the packetizer FSM encoding. The router input
// stage decodes the same field offsets.
package ni_packetizer_pkg;

    // Two-bit flit type carried in the top bits of every flit
    typedef enum logic [1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_HEAD     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    // Node address width and head-flit field positions
    localparam int ADDR_W  = 3;
    localparam int DST_LSB = 0;
    localparam int SRC_LSB = 3;
    localparam int LEN_LSB = 6;

    // Packetizer control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } ni_state_e;

endpackage

// File: rtl/ni_credit_counter.sv
// Credit tracker for the router's local input buffer. Starts full, goes down
// on every flit sent and up on every returned credit. A credit returned while
// already full is an error; the count saturates and a sticky flag is raised.
module ni_credit_counter
    import ni_packetizer_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int CRD_W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic send_i,
    input  logic credit_i,
    output logic can_send_o,
    output logic credit_err_o
);

    localparam logic [CRD_W-1:0] CNT_FULL = CRD_W'(BUF_DEPTH);

    logic [CRD_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Next count: a send and a credit in the same cycle cancel each other out
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (send_i && !credit_i) begin
            cnt_d = cnt_q - CRD_W'(1);
        end else if (!send_i && credit_i) begin
            if (cnt_q == CNT_FULL) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CRD_W'(1);
            end
        end
    end

    // Counter and sticky error register, back to a full buffer on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_FULL;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign can_send_o   = (cnt_q != '0);
    assign credit_err_o = err_q;

endmodule

// File: rtl/ni_packetizer.sv
// Transmit-side network interface: turns a packet request plus a stream of
// payload words into head/body/tail flits for the router's local input port,
// paced by credits returned from the router.
module ni_packetizer
    import ni_packetizer_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 4,
    parameter int BUF_DEPTH = 4,
    parameter int CRD_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        router_add,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_dst,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              dat_valid,
    output logic              dat_ready,
    input  logic [DATA_W-1:0] dat_data,
    output logic              flit_valid,
    output logic [DATA_W+1:0] flit_data,
    input  logic              credit_in,
    output logic              credit_err
);

    ni_state_e         state_q, state_d;
    logic [2:0]        dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              flit_valid_q, flit_valid_d;
    logic [DATA_W+1:0] flit_data_q, flit_data_d;
    logic [DATA_W-1:0] head_payload;
    flit_type_e        flit_type;
    logic              send;
    logic              can_send;

    ni_credit_counter #(
        .BUF_DEPTH (BUF_DEPTH),
        .CRD_W     (CRD_W)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .send_i       (send),
        .credit_i     (credit_in),
        .can_send_o   (can_send),
        .credit_err_o (credit_err)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave BODY only on the handshake of the last word
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid && req_ready) state_d = ST_HEAD;
            ST_HEAD: if (send) state_d = (len_q == '0) ? ST_IDLE : ST_BODY;
            ST_BODY: if (send && rem_q == LEN_W'(1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshakes and the send strobe, all held off during reset
    always_comb begin
        req_ready = 1'b0;
        dat_ready = 1'b0;
        send      = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: req_ready = 1'b1;
                ST_HEAD: send      = can_send;
                ST_BODY: begin
                    dat_ready = can_send;
                    send      = dat_valid && can_send;
                end
                default: ;
            endcase
        end
    end

    // Head payload assembled from the latched request and this node's address
    always_comb begin
        head_payload                      = '0;
        head_payload[DST_LSB +: ADDR_W]   = dst_q;
        head_payload[SRC_LSB +: ADDR_W]   = router_add;
        head_payload[LEN_LSB +: LEN_W]    = len_q;
    end

    // Flit to emit this cycle and the remaining-word count after it
    always_comb begin
        flit_valid_d = send;
        flit_data_d  = flit_data_q;
        rem_d        = rem_q;
        flit_type    = FLIT_BODY;
        if (send && state_q == ST_HEAD) begin
            flit_type   = (len_q == '0) ? FLIT_HEADTAIL : FLIT_HEAD;
            flit_data_d = {flit_type, head_payload};
            rem_d       = len_q;
        end else if (send && state_q == ST_BODY) begin
            flit_type   = (rem_q == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
            flit_data_d = {flit_type, dat_data};
            rem_d       = rem_q - LEN_W'(1);
        end
    end

    // Datapath registers; flit_data holds its value between emissions
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q        <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            flit_valid_q <= 1'b0;
            flit_data_q  <= '0;
        end else begin
            if (req_valid && req_ready) begin
                dst_q <= req_dst;
                len_q <= req_len;
            end
            rem_q        <= rem_d;
            flit_valid_q <= flit_valid_d;
            flit_data_q  <= flit_data_d;
        end
    end

    assign flit_valid = flit_valid_q;
    assign flit_data  = flit_data_q;

endmodule

// File: tb/tb_ni_packetizer.sv
// Self-checking bench for ni_packetizer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural packet model.
module tb_ni_packetizer;

    localparam int DATA_W    = 32;
    localparam int LEN_W     = 4;
    localparam int BUF_DEPTH = 4;
    localparam int CRD_W     = 3;
    localparam int FLIT_W    = DATA_W + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        router_add = '0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_dst = '0;
    logic [LEN_W-1:0]  req_len = '0;
    logic              dat_valid = 1'b0;
    logic              dat_ready;
    logic [DATA_W-1:0] dat_data = '0;
    logic              flit_valid;
    logic [FLIT_W-1:0] flit_data;
    logic              credit_in = 1'b0;
    logic              credit_err;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: packet in flight, words still owed, credits held
    bit                mBusy     = 1'b0;
    bit                mHeadSent = 1'b0;
    int                mWordsLeft = 0;
    int                mCredits  = BUF_DEPTH;
    bit                mErr      = 1'b0;
    bit                mExpValid = 1'b0;
    logic [FLIT_W-1:0] mExpData  = '0;
    int                mDst      = 0;
    int                mLen      = 0;

    // Directed-test flit bookkeeping
    int                dirFlits = 0;
    logic [FLIT_W-1:0] dirLast  = '0;

    ni_packetizer #(
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .BUF_DEPTH (BUF_DEPTH),
        .CRD_W     (CRD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .router_add (router_add),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dst    (req_dst),
        .req_len    (req_len),
        .dat_valid  (dat_valid),
        .dat_ready  (dat_ready),
        .dat_data   (dat_data),
        .flit_valid (flit_valid),
        .flit_data  (flit_data),
        .credit_in  (credit_in),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    // One comparison with its pass/fail accounting
    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    task automatic checkOutput();
        checkValue("req_ready",  64'(req_ready),  64'(!rst && !mBusy));
        checkValue("dat_ready",  64'(dat_ready),  64'(!rst && mBusy && mHeadSent && mCredits > 0));
        checkValue("flit_valid", 64'(flit_valid), 64'(mExpValid));
        checkValue("flit_data",  64'(flit_data),  64'(mExpData));
        checkValue("credit_err", 64'(credit_err), 64'(mErr));
    endtask

    // Advance the model over the coming clock edge using the current inputs
    task automatic stepModel();
        bit send;
        send = 1'b0;
        if (rst) begin
            mBusy = 0; mHeadSent = 0; mWordsLeft = 0; mCredits = BUF_DEPTH;
            mErr = 0; mExpValid = 0; mExpData = '0;
        end else begin
            mExpValid = 0;
            if (!mBusy) begin
                if (req_valid) begin
                    mBusy = 1; mHeadSent = 0;
                    mDst = int'(req_dst); mLen = int'(req_len);
                end
            end else if (!mHeadSent) begin
                if (mCredits > 0) begin
                    send = 1; mExpValid = 1; mHeadSent = 1; mWordsLeft = mLen;
                    mExpData[DATA_W-1:0] = DATA_W'(mDst + 8 * int'(router_add) + 64 * mLen);
                    mExpData[FLIT_W-1:DATA_W] = (mLen == 0) ? 2'b11 : 2'b01;
                    if (mLen == 0) mBusy = 0;
                end
            end else if (dat_valid && mCredits > 0) begin
                send = 1; mExpValid = 1;
                mExpData = {((mWordsLeft == 1) ? 2'b10 : 2'b00), dat_data};
                mWordsLeft--;
                if (mWordsLeft == 0) mBusy = 0;
            end
            if (send && !credit_in) mCredits--;
            else if (!send && credit_in) begin
                if (mCredits == BUF_DEPTH) mErr = 1;
                else mCredits++;
            end
        end
    endtask

    // Compare process: check outputs, then step the model, every falling edge
    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
            stepModel();
        end
    end

    // Drive every stimulus input at once
    task automatic applyStimulus(input logic rv, input logic [2:0] dst, input logic [LEN_W-1:0] len,
                                 input logic dv, input logic [DATA_W-1:0] dd, input logic crd);
        req_valid = rv; req_dst = dst; req_len = len;
        dat_valid = dv; dat_data = dd; credit_in = crd;
    endtask

    // Move to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Advance one cycle and record any flit that appeared
    task automatic cycCount();
        cyc();
        if (flit_valid) begin
            dirFlits++;
            dirLast = flit_data;
        end
    endtask

    // Return credits until the model shows a full buffer
    task automatic refill();
        for (int i = 0; i < 2 * BUF_DEPTH && mCredits < BUF_DEPTH; i++) begin
            credit_in = 1'b1;
            cyc();
        end
        credit_in = 1'b0;
    endtask

    initial begin
        applyStimulus(0, 3'd0, '0, 0, '0, 0);
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        checkValue("reset flit_valid", 64'(flit_valid), 64'd0);
        checkValue("reset flit_data",  64'(flit_data),  64'd0);
        checkValue("reset credit_err", 64'(credit_err), 64'd0);
        checkValue("idle req_ready",   64'(req_ready),  64'd1);

        // Single-flit packet to node 110 from node 000
        router_add = 3'b000;
        applyStimulus(1, 3'b110, 4'd0, 0, '0, 0);
        cyc();
        applyStimulus(0, 3'd0, '0, 0, '0, 0);
        cyc();
        checkValue("headtail valid", 64'(flit_valid), 64'd1);
        checkValue("headtail data",  64'(flit_data),  64'h3_0000_0006);
        cyc();
        checkValue("headtail one-shot", 64'(flit_valid), 64'd0);
        refill();

        // Three-word packet, words back to back
        router_add = 3'b001;
        applyStimulus(1, 3'b011, 4'd3, 0, '0, 0);
        cyc();
        applyStimulus(0, 3'd0, '0, 1, 32'hA0A0_0000, 0);
        cyc();
        checkValue("head3 data",  64'(flit_data), 64'h1_0000_00CB);
        checkValue("head3 busy",  64'(req_ready), 64'd0);
        cyc();
        checkValue("body A0", 64'(flit_data), 64'h0_A0A0_0000);
        dat_data = 32'hA1A1_0001;
        cyc();
        checkValue("body A1", 64'(flit_data), 64'h0_A1A1_0001);
        checkValue("body busy", 64'(req_ready), 64'd0);
        dat_data = 32'hA2A2_0002;
        cyc();
        checkValue("tail A2", 64'(flit_data), 64'h2_A2A2_0002);
        checkValue("tail idle", 64'(req_ready), 64'd1);
        dat_valid = 1'b0;
        refill();

        // Credit stall on a five-word packet
        router_add = 3'b010;
        dirFlits = 0;
        applyStimulus(1, 3'b101, 4'd5, 0, '0, 0);
        cycCount();
        applyStimulus(0, 3'd0, '0, 1, $urandom, 0);
        repeat (15) begin cycCount(); dat_data = $urandom; end
        checkValue("stall flits", 64'(dirFlits), 64'd4);
        checkValue("stall dat_ready", 64'(dat_ready), 64'd0);
        credit_in = 1'b1; cycCount(); credit_in = 1'b0;
        repeat (5) cycCount();
        checkValue("one credit flits", 64'(dirFlits), 64'd5);
        credit_in = 1'b1; cycCount(); credit_in = 1'b0;
        repeat (5) cycCount();
        checkValue("released flits", 64'(dirFlits), 64'd6);
        checkValue("released tail type", 64'(dirLast[FLIT_W-1:DATA_W]), 64'd2);
        dat_valid = 1'b0;
        refill();

        // Spurious credit at a full counter, sticky until reset
        credit_in = 1'b1; cyc(); credit_in = 1'b0;
        checkValue("credit_err set", 64'(credit_err), 64'd1);
        repeat (3) cyc();
        checkValue("credit_err held", 64'(credit_err), 64'd1);
        rst = 1'b1; cyc(); rst = 1'b0;
        #1;
        checkValue("credit_err cleared", 64'(credit_err), 64'd0);

        // Reset after the second body flit of a four-word packet
        router_add = 3'b011;
        dirFlits = 0;
        applyStimulus(1, 3'b111, 4'd4, 0, '0, 0);
        cycCount();
        applyStimulus(0, 3'd0, '0, 1, $urandom, 0);
        for (int i = 0; i < 10 && dirFlits < 3; i++) begin
            cycCount();
            dat_data = $urandom;
        end
        checkValue("abort point flits", 64'(dirFlits), 64'd3);
        rst = 1'b1; cyc(); rst = 1'b0;
        #1;
        checkValue("abort flit_valid", 64'(flit_valid), 64'd0);
        checkValue("abort req_ready",  64'(req_ready),  64'd1);
        checkValue("abort dat_ready",  64'(dat_ready),  64'd0);
        dat_valid = 1'b0;
        dirFlits = 0;
        repeat (4) cycCount();
        checkValue("abort no tail", 64'(dirFlits), 64'd0);

        // Randomized traffic against the model
        router_add = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 3) == 0);
            req_dst   = 3'($urandom_range(0, 7));
            req_len   = LEN_W'($urandom_range(0, 15));
            dat_valid = ($urandom_range(0, 9) < 7);
            dat_data  = $urandom;
            credit_in = (mCredits < BUF_DEPTH && $urandom_range(0, 2) == 0) ||
                        ($urandom_range(0, 999) == 0);
            rst       = ($urandom_range(0, 699) == 0);
            cyc();
        end
        applyStimulus(0, 3'd0, '0, 0, '0, 0);
        rst = 1'b0;
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
